// File: rtl/apb_req_queue_if.sv
// apb_req_queue_if
//   Bundles the request port, the head-request outputs towards the APB
//   master, the APB bus monitor inputs, the response port and the status
//   outputs of apb_req_queue. PCLK/PRESETn stay plain ports on the module.
//
//   modport slave  : the queue's view (what apb_req_queue uses as its port)
//   modport master : the surrounding system's view (request source, APB
//                    master/slave, response sink)
//
//   Signals:
//     cmd_valid/cmd_ready, cmd_write/addr/wdata/strb/prot   request port
//     SWRITE/SADDR/SWDATA/SSTRB/SPROT, transfer              head request to master
//     PSEL/PENABLE/PREADY/PSLVERR/PRDATA                     APB bus monitor
//     rsp_valid/rsp_ready, rsp_write/err/rdata               response port
//     busy, timeout_flag                                     status
interface apb_req_queue_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned STRB_W = 4,
   parameter int unsigned PROT_W = 3
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;
   logic [PROT_W-1:0] cmd_prot;

   logic              SWRITE;
   logic [ADDR_W-1:0] SADDR;
   logic [DATA_W-1:0] SWDATA;
   logic [STRB_W-1:0] SSTRB;
   logic [PROT_W-1:0] SPROT;
   logic              transfer;

   logic              PSEL;
   logic              PENABLE;
   logic              PREADY;
   logic              PSLVERR;
   logic [DATA_W-1:0] PRDATA;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_write;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   logic              busy;
   logic              timeout_flag;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      output cmd_ready,
      output SWRITE, SADDR, SWDATA, SSTRB, SPROT, transfer,
      input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
      output rsp_valid, rsp_write, rsp_err, rsp_rdata,
      input  rsp_ready,
      output busy, timeout_flag
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      input  cmd_ready,
      input  SWRITE, SADDR, SWDATA, SSTRB, SPROT, transfer,
      output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
      input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
      output rsp_ready,
      input  busy, timeout_flag
   );
endinterface

// File: rtl/apb_req_queue.sv
// apb_req_queue
//   Command/response queue in front of the APB master. Requests are buffered
//   in a DEPTH-entry command FIFO; the oldest one is presented on S* with
//   'transfer' asserted. An APB completion (PSEL & PENABLE & PREADY) pops the
//   command head and pushes {write, PSLVERR, read data} into a DEPTH-entry
//   response FIFO. Commands are only accepted while cmd_cnt + rsp_cnt < DEPTH,
//   so every issued command always has a response slot.
//
//   Ports:
//     PCLK     clock, rising edge
//     PRESETn  asynchronous active-low reset; discards all queued state
//     bus      apb_req_queue_if.slave (request, head, bus monitor, response,
//              busy, timeout_flag)
//
//   Optional feature: define APB_REQQ_TIMEOUT_EN to build the wait-state
//   counter driving the sticky timeout_flag (set after TIMEOUT_CYCLES
//   consecutive wait states). Without it timeout_flag is constant 0.
module apb_req_queue #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned STRB_W         = 4,
   parameter int unsigned PROT_W         = 3,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   apb_req_queue_if.slave    bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("apb_req_queue: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
      $error("apb_req_queue: TIMEOUT_CYCLES must be >= 1");
   end

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] strb;
      logic [PROT_W-1:0] prot;
   } cmd_t;

   typedef struct packed {
      logic              write;
      logic              err;
      logic [DATA_W-1:0] rdata;
   } rsp_t;

   cmd_t             cmd_mem_q [DEPTH];
   cmd_t             cmd_mem_d [DEPTH];
   rsp_t             rsp_mem_q [DEPTH];
   rsp_t             rsp_mem_d [DEPTH];

   logic [PTR_W-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
   logic [PTR_W-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
   logic [PTR_W-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
   logic [PTR_W-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
   logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
   logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;

   logic [CNT_W:0]   occupancy;
   logic             cmd_ready;
   logic             cmd_nonempty;
   logic             rsp_nonempty;
   logic             push;
   logic             done;
   logic             rsp_pop;
   cmd_t             cmd_in;
   cmd_t             cmd_head;
   rsp_t             rsp_head;
   rsp_t             rsp_new;

   // Readiness depends on registered counts only; no combinational path
   // from cmd_valid.
   assign occupancy    = {1'b0, cmd_cnt_q} + {1'b0, rsp_cnt_q};
   assign cmd_ready    = occupancy < (CNT_W + 1)'(DEPTH);
   assign cmd_nonempty = (cmd_cnt_q != '0);
   assign rsp_nonempty = (rsp_cnt_q != '0);

   assign push    = bus.cmd_valid & cmd_ready;
   // A completion with nothing queued is spurious and ignored.
   assign done    = bus.PSEL & bus.PENABLE & bus.PREADY & cmd_nonempty;
   assign rsp_pop = rsp_nonempty & bus.rsp_ready;

   always_comb begin
      cmd_in       = '0;
      cmd_in.write = bus.cmd_write;
      cmd_in.addr  = bus.cmd_addr;
      cmd_in.wdata = bus.cmd_wdata;
      cmd_in.strb  = bus.cmd_strb;
      cmd_in.prot  = bus.cmd_prot;

      cmd_head = cmd_nonempty ? cmd_mem_q[cmd_rd_ptr_q] : '0;
      rsp_head = rsp_nonempty ? rsp_mem_q[rsp_rd_ptr_q] : '0;

      rsp_new       = '0;
      rsp_new.write = cmd_head.write;
      rsp_new.err   = bus.PSLVERR;
      rsp_new.rdata = cmd_head.write ? '0 : bus.PRDATA;
   end

   always_comb begin
      cmd_mem_d    = cmd_mem_q;
      rsp_mem_d    = rsp_mem_q;
      cmd_wr_ptr_d = cmd_wr_ptr_q;
      cmd_rd_ptr_d = cmd_rd_ptr_q;
      rsp_wr_ptr_d = rsp_wr_ptr_q;
      rsp_rd_ptr_d = rsp_rd_ptr_q;

      if (push) begin
         cmd_mem_d[cmd_wr_ptr_q] = cmd_in;
         cmd_wr_ptr_d            = cmd_wr_ptr_q + PTR_W'(1);
      end
      if (done) begin
         cmd_rd_ptr_d            = cmd_rd_ptr_q + PTR_W'(1);
         rsp_mem_d[rsp_wr_ptr_q] = rsp_new;
         rsp_wr_ptr_d            = rsp_wr_ptr_q + PTR_W'(1);
      end
      if (rsp_pop) begin
         rsp_rd_ptr_d = rsp_rd_ptr_q + PTR_W'(1);
      end

      // Push, completion and pop may coincide; each count sees its own
      // increment and decrement so the total moves by push - pop.
      cmd_cnt_d = cmd_cnt_q + CNT_W'(push) - CNT_W'(done);
      rsp_cnt_d = rsp_cnt_q + CNT_W'(done) - CNT_W'(rsp_pop);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cmd_wr_ptr_q <= '0;
         cmd_rd_ptr_q <= '0;
         rsp_wr_ptr_q <= '0;
         rsp_rd_ptr_q <= '0;
         cmd_cnt_q    <= '0;
         rsp_cnt_q    <= '0;
      end else begin
         cmd_wr_ptr_q <= cmd_wr_ptr_d;
         cmd_rd_ptr_q <= cmd_rd_ptr_d;
         rsp_wr_ptr_q <= rsp_wr_ptr_d;
         rsp_rd_ptr_q <= rsp_rd_ptr_d;
         cmd_cnt_q    <= cmd_cnt_d;
         rsp_cnt_q    <= rsp_cnt_d;
      end
   end

   // Storage needs no reset: every read is gated by a non-zero count.
   always_ff @(posedge PCLK) begin
      cmd_mem_q <= cmd_mem_d;
      rsp_mem_q <= rsp_mem_d;
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.SWRITE    = cmd_head.write;
   assign bus.SADDR     = cmd_head.addr;
   assign bus.SWDATA    = cmd_head.wdata;
   assign bus.SSTRB     = cmd_head.strb;
   assign bus.SPROT     = cmd_head.prot;
   // When the head completes this cycle, only a further entry may start a
   // new SETUP; the completing head is never replayed and a command pushed
   // this same cycle is not bypassed.
   assign bus.transfer  = done ? (cmd_cnt_q >= CNT_W'(2)) : cmd_nonempty;

   assign bus.rsp_valid = rsp_nonempty;
   assign bus.rsp_write = rsp_head.write;
   assign bus.rsp_err   = rsp_head.err;
   assign bus.rsp_rdata = rsp_head.rdata;
   assign bus.busy      = cmd_nonempty | rsp_nonempty;

`ifdef APB_REQQ_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic              stalled;

   assign stalled = bus.PSEL & bus.PENABLE & ~bus.PREADY;

   always_comb begin
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      if (stalled) begin
         // Saturate so a very long stall cannot wrap the counter.
         wait_cnt_d = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES)) ? wait_cnt_q
                                                             : wait_cnt_q + WAIT_W'(1);
         if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.timeout_flag = timeout_q;
`else
   assign bus.timeout_flag = 1'b0;
`endif

endmodule

// File: doc/apb_req_queue.md
# apb_req_queue

Command/response queue sitting directly upstream of the APB master in the APB4 RAM subsystem. It accepts transfer requests from the external system over a valid/ready port and buffers up to DEPTH of them. It presents the oldest request to the master's system-side inputs (SWRITE/SADDR/SWDATA/SSTRB/SPROT/transfer) and monitors the APB bus for completion. It returns one response (read data, error, direction) per completed transfer, in order.

## Interface
- DEPTH, 4: total entries shared by the command and response queues; power of two, ≥2
- ADDR_W, 32: address width
- DATA_W, 32: data width
- STRB_W, 4: write strobe width
- PROT_W, 3: protection width
- TIMEOUT_CYCLES, 16: wait-state limit, used only with the timeout feature
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  request handshake
- cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot  in  1/ADDR_W/DATA_W/STRB_W/PROT_W  request fields
- SWRITE, SADDR, SWDATA, SSTRB, SPROT  out  1/ADDR_W/DATA_W/STRB_W/PROT_W  head request to master
- transfer  out  1  request pending, to master
- PSEL, PENABLE, PREADY, PSLVERR  in  1  bus monitor
- PRDATA  in  DATA_W  read data from slave
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  direction of the completed transfer
- rsp_err  out  1  PSLVERR captured at completion
- rsp_rdata  out  DATA_W  PRDATA captured at completion; 0 for writes
- busy  out  1  cmd_cnt≠0 or rsp_cnt≠0
- timeout_flag  out  1  sticky wait-state timeout

## Operation
- Two circular FIFOs, each with DEPTH entries and its own pointers: command and response. Counts cmd_cnt and rsp_cnt are registered.
- cmd_ready = (cmd_cnt + rsp_cnt) < DEPTH. It is a function of registered counts only, with no path from cmd_valid. This guarantees every issued command has a response slot.
- Push: cmd_valid & cmd_ready at an edge writes the tail entry and increments cmd_cnt.
- Head: S* outputs = command entry at the read pointer while cmd_cnt≠0, all zeros when empty. The head stays stable until its completion edge. The master captures S* during SETUP and relies on that stability.
- Completion: done = PSEL & PENABLE & PREADY with cmd_cnt≠0. At that edge:
  - the command head pops;
  - the response entry {write, PSLVERR, write ? 0 : PRDATA} is pushed.
  - Total occupancy is unchanged.
- done with cmd_cnt=0 is a spurious completion: it is ignored, with no response and no counter change.
- transfer = (cmd_cnt ≥ 2) when done, else (cmd_cnt ≥ 1). The master therefore re-enters SETUP only if a further command exists, and never replays the in-flight head.
- No bypass: a command pushed in the same cycle that the last entry completes is not visible until the next cycle. The master goes IDLE for one cycle, then SETUP.
- Response pop: rsp_valid & rsp_ready at an edge decrements rsp_cnt. rsp_valid = rsp_cnt≠0, and rsp_* show the head response, all zeros when empty.
- Push, completion and response pop may all occur at the same edge. All counts update consistently, with no loss and no duplication.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, immediate): both FIFOs are emptied, and queued commands and responses are discarded. Resulting outputs:
  - cmd_ready=1, transfer=0;
  - S* = 0;
  - rsp_valid=0, rsp_write=0, rsp_err=0, rsp_rdata=0;
  - busy=0, timeout_flag=0.
- A reset mid-transfer drops the in-flight command; no response is produced for it.
- Command accepted at edge N → transfer=1 during cycle N+1 → master SETUP at N+2 → ACCESS at N+3.
- Completion at edge M → rsp_valid=1 during cycle M+1 (one-cycle latency).
- Back-to-back: with ≥2 commands queued, the next SETUP directly follows the completing ACCESS cycle. There are no idle cycles.

## Configuration
- APB_REQQ_TIMEOUT_EN defined:
  - A wait counter increments each cycle with PSEL & PENABLE & !PREADY, and clears otherwise.
  - When the count reaches TIMEOUT_CYCLES, timeout_flag sets at that edge and stays set until reset. The transfer is not aborted.
- Not defined: no counter is built and timeout_flag is tied to 0.

## Test plan
- Single write cmd (addr 0x10, data 0xA5A5A5A5, strb 0xF), slave PREADY immediate → SADDR=0x10 held through SETUP/ACCESS; one response with rsp_write=1, rsp_err=0, rsp_rdata=0; busy drops after the pop.
- Four cmds pushed back-to-back with rsp_ready=0 (DEPTH=4) → cmd_ready=0 after the 4th push; four APB transfers with no idle between them; 5th push accepted only in the cycle after the first response pops.
- Read from 0x20 with slave PRDATA=0x12345678, PSLVERR=1, 2 wait states → rsp_rdata=0x12345678, rsp_err=1, rsp_valid one cycle after the PREADY edge.
- Last entry completes while a new cmd is pushed in the same cycle → transfer=0 for one cycle, master IDLE one cycle, then the new SETUP; no replay of the old head.
- PRESETn pulsed low mid-ACCESS with 3 cmds queued → all outputs at reset values immediately; no responses after release.
- With APB_REQQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held low 20 cycles → timeout_flag rises after 16 wait cycles and stays 1 after completion; without the macro it stays 0.
